spi_rx_word_packer: RTL and testbench

SPI_RX_WORD_PACKER -- requirements
Module: spi_rx_word_packer
Placement: downstream of the SPI slave RX byte stream; packs received bytes into 32-bit bus words.

---
 rtl/spi_rx_word_packer.sv | 118 +++++++++++
 tb/tb_spi_rx_word_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_word_packer.sv
// Packs the SPI slave RX byte stream into 32-bit bus words with a single-entry
// output register, frame-end / idle-timeout flushing and a sticky overflow flag.
module spi_rx_word_packer #(
  parameter bit          BigEndian   = 1'b0,
  parameter int unsigned IdleTimeout = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  input  logic        frame_end_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic [2:0]  word_bytes_o,
  output logic        overflow_o,
  input  logic        ovf_clr_i
);

  // Output handshake: a word transfers at a rising edge where word_valid_o and
  // word_ready_i are both high; while valid waits for ready, data and bytes hold.

  localparam logic [16:0] IdleLimit = 17'(IdleTimeout);

  logic [31:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_pend;
  logic [15:0] r_idle;
  logic        r_valid;
  logic [31:0] r_data;
  logic [2:0]  r_bytes;
  logic        r_ovf;

  logic        w_slot_free;
  logic        w_accept;
  logic        w_drop;
  logic [1:0]  w_lane;
  logic [31:0] w_acc_n;
  logic [2:0]  w_cnt_n;
  logic        w_counting;
  logic        w_timeout;
  logic        w_complete;
  logic        w_load;

  always_comb begin
    w_slot_free = !r_valid || word_ready_i;
    w_accept    = byte_valid_i && (r_cnt < 3'd4) && !r_pend;
    w_drop      = byte_valid_i && ((r_cnt == 3'd4) || r_pend);
    // In big-endian mode lane 3-k is simply the bitwise inverse of k.
    w_lane      = BigEndian ? ~r_cnt[1:0] : r_cnt[1:0];

    w_acc_n = r_acc;
    w_cnt_n = r_cnt;
    if (w_accept) begin
      w_acc_n[{w_lane, 3'b000} +: 8] = byte_data_i;
      w_cnt_n = r_cnt + 3'd1;
    end

    w_counting = (IdleTimeout != 0) && (r_cnt != 3'd0) && (r_cnt < 3'd4) &&
                 !r_pend && !w_accept;
    // Fire on the idle cycle that brings the count up to the limit.
    w_timeout  = w_counting && (({1'b0, r_idle} + 17'd1) == IdleLimit);

    w_complete = r_pend ||
                 (w_accept && (w_cnt_n == 3'd4)) ||
                 (frame_end_i && (w_cnt_n != 3'd0)) ||
                 w_timeout;
    w_load     = w_complete && w_slot_free;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_idle  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_bytes <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_acc_n;
        r_bytes <= w_cnt_n;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
      end else begin
        if (r_valid && word_ready_i) begin
          r_valid <= 1'b0;
        end
        r_acc  <= w_acc_n;
        r_cnt  <= w_cnt_n;
        r_pend <= w_complete;
      end

      if (w_accept || w_complete) begin
        r_idle <= '0;
      end else if (w_counting) begin
        r_idle <= r_idle + 16'd1;
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign word_valid_o = r_valid;
  assign word_data_o  = r_data;
  assign word_bytes_o = r_bytes;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_spi_rx_word_packer.sv
// Bench for spi_rx_word_packer: a little-endian instance with a 10-cycle idle
// timeout and a big-endian instance without timeout share one input stream.
module tb_spi_rx_word_packer;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_end;
  logic        word_ready;
  logic        ovf_clr;

  logic        le_valid, be_valid;
  logic [31:0] le_data, be_data;
  logic [2:0]  le_bytes, be_bytes;
  logic        le_ovf, be_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected words as {bytes, data}; matching queue of expected rise edges (-1: don't care).
  logic [34:0] exp_le_q[$];
  logic [34:0] exp_be_q[$];
  int          cyc_le_q[$];
  int          cyc_be_q[$];

  spi_rx_word_packer #(.BigEndian(1'b0), .IdleTimeout(10)) u_le (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .frame_end_i(frame_end), .word_valid_o(le_valid), .word_ready_i(word_ready),
    .word_data_o(le_data), .word_bytes_o(le_bytes), .overflow_o(le_ovf),
    .ovf_clr_i(ovf_clr)
  );

  spi_rx_word_packer #(.BigEndian(1'b1), .IdleTimeout(0)) u_be (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .frame_end_i(frame_end), .word_valid_o(be_valid), .word_ready_i(word_ready),
    .word_data_o(be_data), .word_bytes_o(be_bytes), .overflow_o(be_ovf),
    .ovf_clr_i(ovf_clr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic bv, input logic [7:0] d, input logic fe, input logic clr);
    byte_valid = bv;
    byte_data  = d;
    frame_end  = fe;
    ovf_clr    = clr;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    frame_end  = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push_le(input logic [34:0] w, input int c);
    exp_le_q.push_back(w);
    cyc_le_q.push_back(c);
  endtask

  task automatic push_be(input logic [34:0] w, input int c);
    exp_be_q.push_back(w);
    cyc_be_q.push_back(c);
  endtask

  task automatic chk(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " le_valid"}, 35'(le_valid), 35'd0);
    chk({tag, " le_data"},  35'(le_data),  35'd0);
    chk({tag, " le_bytes"}, 35'(le_bytes), 35'd0);
    chk({tag, " le_ovf"},   35'(le_ovf),   35'd0);
    chk({tag, " be_valid"}, 35'(be_valid), 35'd0);
    chk({tag, " be_data"},  35'(be_data),  35'd0);
    chk({tag, " be_bytes"}, 35'(be_bytes), 35'd0);
    chk({tag, " be_ovf"},   35'(be_ovf),   35'd0);
  endtask

  // ---------------- scoreboard monitors ----------------
  logic        le_prev_valid = 1'b0, be_prev_valid = 1'b0;
  logic        le_prev_ready = 1'b0, be_prev_ready = 1'b0;
  logic [34:0] le_hold, be_hold, le_exp, be_exp;
  int          le_rise = -1, be_rise = -1, le_ec, be_ec;

  always @(negedge clk) begin
    if (!rst) begin
      if (le_valid && !le_prev_valid) le_rise = cyc;
      if (le_prev_valid && !le_prev_ready && le_valid)
        chk("le_hold", {le_bytes, le_data}, le_hold);
      if (le_valid && word_ready) begin
        if (exp_le_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL le_unexpected got=%h exp=none", {le_bytes, le_data});
        end else begin
          le_exp = exp_le_q.pop_front();
          le_ec  = cyc_le_q.pop_front();
          chk("le_word", {le_bytes, le_data}, le_exp);
          if (le_ec >= 0) chk("le_latency", 35'(le_rise), 35'(le_ec));
        end
      end
    end
    le_prev_valid = le_valid && !rst;
    le_prev_ready = word_ready;
    le_hold       = {le_bytes, le_data};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (be_valid && !be_prev_valid) be_rise = cyc;
      if (be_prev_valid && !be_prev_ready && be_valid)
        chk("be_hold", {be_bytes, be_data}, be_hold);
      if (be_valid && word_ready) begin
        if (exp_be_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL be_unexpected got=%h exp=none", {be_bytes, be_data});
        end else begin
          be_exp = exp_be_q.pop_front();
          be_ec  = cyc_be_q.pop_front();
          chk("be_word", {be_bytes, be_data}, be_exp);
          if (be_ec >= 0) chk("be_latency", 35'(be_rise), 35'(be_ec));
        end
      end
    end
    be_prev_valid = be_valid && !rst;
    be_prev_ready = word_ready;
    be_hold       = {be_bytes, be_data};
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    frame_end  = 1'b0;
    word_ready = 1'b1;
    ovf_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Full word, consumer always ready; valid one cycle after the 4th byte.
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    push_le({3'd4, 32'h44332211}, cyc);
    push_be({3'd4, 32'h11223344}, cyc);
    idle(3);

    // Partial word flushed by frame_end, then frame_end on an empty accumulator.
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push_le({3'd2, 32'h0000BBAA}, cyc);
    push_be({3'd2, 32'hAABB0000}, cyc);
    idle(2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // Byte and frame_end in the same cycle: the byte is included.
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    drive(1'b1, 8'h34, 1'b1, 1'b0);
    push_le({3'd2, 32'h00003412}, cyc);
    push_be({3'd2, 32'h12340000}, cyc);
    idle(3);

    // Backpressure: 8 bytes fill slot and accumulator, the 9th is dropped.
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    push_le({3'd4, 32'h04030201}, -1);
    push_le({3'd4, 32'h08070605}, -1);
    push_be({3'd4, 32'h01020304}, -1);
    push_be({3'd4, 32'h05060708}, -1);
    chk("le_ovf_before_drop", 35'(le_ovf), 35'd0);
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    chk("le_ovf_set", 35'(le_ovf), 35'd1);
    chk("be_ovf_set", 35'(be_ovf), 35'd1);
    idle(3);
    chk("le_ovf_sticky", 35'(le_ovf), 35'd1);
    drive(1'b1, 8'h0A, 1'b0, 1'b1);
    chk("le_ovf_clr_vs_drop", 35'(le_ovf), 35'd1);
    chk("be_ovf_clr_vs_drop", 35'(be_ovf), 35'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("le_ovf_cleared", 35'(le_ovf), 35'd0);
    chk("be_ovf_cleared", 35'(be_ovf), 35'd0);
    idle(2);
    word_ready = 1'b1;
    idle(4);

    // Idle timeout on the little-endian instance only; big-endian waits for frame_end.
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    push_le({3'd1, 32'h0000005A}, cyc + 10);
    idle(15);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push_be({3'd1, 32'h5A000000}, cyc);
    idle(3);

    // Reset mid-word discards the partial; inputs are ignored during reset.
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    rst        = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    frame_end  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    frame_end  = 1'b0;
    chk_all_zero("midword_reset");
    idle(14);
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    drive(1'b1, 8'hD2, 1'b0, 1'b0);
    drive(1'b1, 8'hD3, 1'b0, 1'b0);
    drive(1'b1, 8'hD4, 1'b0, 1'b0);
    push_le({3'd4, 32'hD4D3D2D1}, cyc);
    push_be({3'd4, 32'hD1D2D3D4}, cyc);
    idle(4);

    for (int i = 0; i < 50 && (exp_le_q.size() != 0 || exp_be_q.size() != 0); i++)
      @(posedge clk);
    chk("le_queue_drained", 35'(exp_le_q.size()), 35'd0);
    chk("be_queue_drained", 35'(exp_be_q.size()), 35'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
